// File: rtl/milano_pkg.sv
// Shared types for the milano core data side.
// Holds the data-memory controller FSM encoding and its wait-counter sizing helper.
package milano_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCESS = 3'd1,
      LATCH  = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4
   } dmem_state_e;

   // A zero-wait configuration still needs a one-bit counter to keep widths legal.
   function automatic int dmem_cnt_width(input int wait_cycles);
      return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
   endfunction

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one outstanding core data transaction at a time,
// driving a synchronous single-port SRAM with byte-write enables.
module dmem_ctrl
   import milano_pkg::*;
#(
   parameter int ADDR_WIDTH  = 14,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  data_req_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   input  logic [31:0]           data_addr_i,
   input  logic                  data_we_i,
   input  logic [3:0]            data_be_i,
   input  logic [31:0]           data_wdata_i,
   output logic [31:0]           data_rdata_o,
   output logic                  data_err_o,
   output logic                  sram_ce_o,
   output logic                  sram_we_o,
   output logic [3:0]            sram_be_o,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [31:0]           sram_wdata_o,
   input  logic [31:0]           sram_rdata_i
);

   localparam int CW = dmem_cnt_width(WAIT_CYCLES);
   localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   dmem_state_e state, state_next;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [3:0]            be_q;
   logic [31:0]           wdata_q;
   logic                  err_q;
   logic [31:0]           rdata_q;
   logic [CW-1:0]         cnt_q;
   logic                  rvalid_q;
   logic [31:0]           rdata_out_q;
   logic                  err_out_q;

   logic                  gnt;
   logic                  resp_set;
   logic [31:0]           latch_val;
   logic                  unused_addr;

   // Sub-word address bits carry no meaning for a word-wide SRAM.
   assign unused_addr = ^data_addr_i[1:0];

   assign latch_val = (we_q || err_q) ? 32'h0 : sram_rdata_i;
   assign resp_set  = ((state == LATCH) && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt_q == '0));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = gnt ? ACCESS : IDLE;
         ACCESS:  state_next = LATCH;
         LATCH:   state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
         WAIT:    state_next = (cnt_q == '0) ? RESP : WAIT;
         RESP:    state_next = gnt ? ACCESS : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Grant is held off while reset is asserted so every output reads 0 in reset.
   always_comb begin
      gnt          = data_req_i && !rst_i && ((state == IDLE) || (state == RESP));
      sram_ce_o    = 1'b0;
      sram_we_o    = 1'b0;
      sram_be_o    = 4'b0000;
      sram_addr_o  = '0;
      sram_wdata_o = 32'h0;
      if (state == ACCESS) begin
         sram_ce_o    = !err_q;
         sram_we_o    = we_q;
         sram_be_o    = be_q;
         sram_addr_o  = addr_q;
         sram_wdata_o = wdata_q;
      end
   end

   assign data_gnt_o    = gnt;
   assign data_rvalid_o = rvalid_q;
   assign data_rdata_o  = rdata_out_q;
   assign data_err_o    = err_out_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q      <= '0;
         we_q        <= 1'b0;
         be_q        <= 4'b0000;
         wdata_q     <= 32'h0;
         err_q       <= 1'b0;
         rdata_q     <= 32'h0;
         cnt_q       <= '0;
         rvalid_q    <= 1'b0;
         rdata_out_q <= 32'h0;
         err_out_q   <= 1'b0;
      end else begin
         if (gnt) begin
            addr_q  <= data_addr_i[ADDR_WIDTH+1:2];
            err_q   <= |data_addr_i[31:ADDR_WIDTH+2];
            we_q    <= data_we_i;
            be_q    <= data_be_i;
            wdata_q <= data_wdata_i;
         end
         if (state == LATCH) begin
            rdata_q <= latch_val;
         end
         if ((state == LATCH) && (WAIT_CYCLES != 0)) begin
            cnt_q <= CNT_LOAD;
         end else if ((state == WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
         end
         // With no wait states the response leaves on the same edge rdata_q loads.
         rvalid_q    <= resp_set;
         rdata_out_q <= resp_set ? ((state == LATCH) ? latch_val : rdata_q) : 32'h0;
         err_out_q   <= resp_set ? err_q : 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a zero-wait instance (u0) and a three-wait
// instance (u3), each backed by a behavioural byte-write SRAM.
module tb_dmem_ctrl;

   localparam int AW = 14;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // u0 : WAIT_CYCLES = 0
   logic          req0 = 1'b0, we0 = 1'b0;
   logic [31:0]   addr0 = '0, wdata0 = '0;
   logic [3:0]    be0 = '0;
   logic          gnt0, rvalid0, err0, ce0, swe0;
   logic [31:0]   rdata0, swdata0;
   logic [31:0]   srd0 = '0;
   logic [3:0]    sbe0;
   logic [AW-1:0] saddr0;
   logic [31:0]   mem0 [0:(1<<AW)-1];

   // u3 : WAIT_CYCLES = 3
   logic          req3 = 1'b0, we3 = 1'b0;
   logic [31:0]   addr3 = '0, wdata3 = '0;
   logic [3:0]    be3 = '0;
   logic          gnt3, rvalid3, err3, ce3, swe3;
   logic [31:0]   rdata3, swdata3;
   logic [31:0]   srd3 = '0;
   logic [3:0]    sbe3;
   logic [AW-1:0] saddr3;
   logic [31:0]   mem3 [0:(1<<AW)-1];

   dmem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u0 (
      .clk_i(clk), .rst_i(rst),
      .data_req_i(req0), .data_gnt_o(gnt0), .data_rvalid_o(rvalid0),
      .data_addr_i(addr0), .data_we_i(we0), .data_be_i(be0), .data_wdata_i(wdata0),
      .data_rdata_o(rdata0), .data_err_o(err0),
      .sram_ce_o(ce0), .sram_we_o(swe0), .sram_be_o(sbe0), .sram_addr_o(saddr0),
      .sram_wdata_o(swdata0), .sram_rdata_i(srd0)
   );

   dmem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) u3 (
      .clk_i(clk), .rst_i(rst),
      .data_req_i(req3), .data_gnt_o(gnt3), .data_rvalid_o(rvalid3),
      .data_addr_i(addr3), .data_we_i(we3), .data_be_i(be3), .data_wdata_i(wdata3),
      .data_rdata_o(rdata3), .data_err_o(err3),
      .sram_ce_o(ce3), .sram_we_o(swe3), .sram_be_o(sbe3), .sram_addr_o(saddr3),
      .sram_wdata_o(swdata3), .sram_rdata_i(srd3)
   );

   always @(posedge clk) begin
      if (ce0) begin
         if (swe0) begin
            for (int b = 0; b < 4; b++)
               if (sbe0[b]) mem0[saddr0][8*b +: 8] <= swdata0[8*b +: 8];
         end else begin
            srd0 <= mem0[saddr0];
         end
      end
   end

   always @(posedge clk) begin
      if (ce3) begin
         if (swe3) begin
            for (int b = 0; b < 4; b++)
               if (sbe3[b]) mem3[saddr3][8*b +: 8] <= swdata3[8*b +: 8];
         end else begin
            srd3 <= mem3[saddr3];
         end
      end
   end

   // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic txn0(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd, output logic e,
                       output int lat);
      cyc(); req0 = 1'b1; addr0 = a; we0 = w; be0 = b; wdata0 = d; #1;
      lat = -1; rd = '0; e = 1'b0;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         cyc(); req0 = 1'b0; #1;
         if (rvalid0) begin lat = c; rd = rdata0; e = err0; end
      end
   endtask

   task automatic txn3(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd, output logic e,
                       output int lat);
      cyc(); req3 = 1'b1; addr3 = a; we3 = w; be3 = b; wdata3 = d; #1;
      lat = -1; rd = '0; e = 1'b0;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         cyc(); req3 = 1'b0; #1;
         if (rvalid3) begin lat = c; rd = rdata3; e = err3; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req0 = 1'b1; req3 = 1'b1;
      cyc(); cyc(); #1;
      checks++;
      if ({gnt0, rvalid0, err0, ce0, swe0, sbe0} !== 9'b0 || rdata0 !== 32'h0 ||
          saddr0 !== '0 || swdata0 !== 32'h0) begin
         failures++;
         $display("FAIL reset_u0: gnt=%b rvalid=%b err=%b ce=%b we=%b be=%b rdata=%h, required all 0",
                  gnt0, rvalid0, err0, ce0, swe0, sbe0, rdata0);
      end
      checks++;
      if ({gnt3, rvalid3, err3, ce3, swe3, sbe3} !== 9'b0 || rdata3 !== 32'h0) begin
         failures++;
         $display("FAIL reset_u3: gnt=%b rvalid=%b err=%b ce=%b rdata=%h, required all 0",
                  gnt3, rvalid3, err3, ce3, rdata3);
      end
      cyc(); rst = 1'b0; req0 = 1'b0; req3 = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_read();
      logic [31:0] rd; logic e; int lat;
      txn0(32'h14, 1'b1, 4'hF, 32'hDEADBEEF, rd, e, lat);
      cyc(); req0 = 1'b1; addr0 = 32'h14; we0 = 1'b0; be0 = 4'hF; #1;
      checks++;
      if (gnt0 !== 1'b1) begin failures++; $display("FAIL read_gnt: got %b required 1", gnt0); end
      cyc(); req0 = 1'b0; #1;
      checks++;
      if (ce0 !== 1'b1 || saddr0 !== 14'd5 || swe0 !== 1'b0) begin
         failures++;
         $display("FAIL read_sram: ce=%b addr=%0d we=%b required ce=1 addr=5 we=0", ce0, saddr0, swe0);
      end
      cyc(); #1;
      checks++;
      if (rvalid0 !== 1'b0 || ce0 !== 1'b0 || gnt0 !== 1'b0) begin
         failures++;
         $display("FAIL read_cycle2: rvalid=%b ce=%b gnt=%b required 0 0 0", rvalid0, ce0, gnt0);
      end
      cyc(); #1;
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || err0 !== 1'b0) begin
         failures++;
         $display("FAIL read_resp: rvalid=%b rdata=%h err=%b required 1 deadbeef 0", rvalid0, rdata0, err0);
      end
      cyc(); #1;
      checks++;
      if (rvalid0 !== 1'b0 || rdata0 !== 32'h0) begin
         failures++;
         $display("FAIL read_pulse: rvalid=%b rdata=%h required 0 0", rvalid0, rdata0);
      end
      $display("test_read done");
   endtask

   task automatic test_byte_write();
      logic [31:0] rd; logic e; int lat;
      cyc(); req0 = 1'b1; addr0 = 32'h14; we0 = 1'b1; be0 = 4'b0010; wdata0 = 32'h0000AA00; #1;
      checks++;
      if (gnt0 !== 1'b1) begin failures++; $display("FAIL bw_gnt: got %b required 1", gnt0); end
      cyc(); req0 = 1'b0; #1;
      checks++;
      if (ce0 !== 1'b1 || swe0 !== 1'b1 || sbe0 !== 4'b0010 || saddr0 !== 14'd5 || swdata0 !== 32'h0000AA00) begin
         failures++;
         $display("FAIL bw_sram: ce=%b we=%b be=%b addr=%0d wdata=%h required 1 1 0010 5 0000aa00",
                  ce0, swe0, sbe0, saddr0, swdata0);
      end
      cyc(); cyc(); #1;
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== 32'h0 || err0 !== 1'b0) begin
         failures++;
         $display("FAIL bw_resp: rvalid=%b rdata=%h err=%b required 1 0 0", rvalid0, rdata0, err0);
      end
      txn0(32'h14, 1'b0, 4'hF, 32'h0, rd, e, lat);
      checks++;
      if (lat !== 3 || rd !== 32'hDEADAAEF || e !== 1'b0) begin
         failures++;
         $display("FAIL bw_readback: lat=%0d rdata=%h err=%b required 3 deadaaef 0", lat, rd, e);
      end
      // Zero byte enables: a write that must leave the word intact.
      txn0(32'h14, 1'b1, 4'b0000, 32'hFFFFFFFF, rd, e, lat);
      checks++;
      if (lat !== 3 || rd !== 32'h0) begin
         failures++;
         $display("FAIL bw_be0_resp: lat=%0d rdata=%h required 3 0", lat, rd);
      end
      txn0(32'h14, 1'b0, 4'hF, 32'h0, rd, e, lat);
      checks++;
      if (rd !== 32'hDEADAAEF) begin
         failures++;
         $display("FAIL bw_be0_readback: rdata=%h required deadaaef", rd);
      end
      $display("test_byte_write done");
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic e; int lat;
      logic [31:0] ad [3];
      logic [31:0] ex [3];
      int ng, nr;
      ad[0] = 32'h4; ad[1] = 32'h8; ad[2] = 32'hC;
      ex[0] = 32'h11111111; ex[1] = 32'h22222222; ex[2] = 32'h33333333;
      for (int i = 0; i < 3; i++) txn0(ad[i], 1'b1, 4'hF, ex[i], rd, e, lat);
      ng = 0; nr = 0;
      for (int c = 0; c < 12; c++) begin
         cyc();
         req0 = (ng < 3); addr0 = ad[(ng < 3) ? ng : 2]; we0 = 1'b0; be0 = 4'hF;
         #1;
         if (rvalid0) begin
            checks++;
            if (nr >= 3 || c != 3 * (nr + 1) || rdata0 !== ex[(nr < 3) ? nr : 2]) begin
               failures++;
               $display("FAIL b2b_resp%0d: cycle=%0d rdata=%h required cycle=%0d", nr, c, rdata0, 3 * (nr + 1));
            end
            nr++;
         end
         if (gnt0) begin
            checks++;
            if (c != 3 * ng) begin
               failures++;
               $display("FAIL b2b_gnt%0d: cycle=%0d required %0d", ng, c, 3 * ng);
            end
            ng++;
         end
      end
      req0 = 1'b0;
      checks++;
      if (ng != 3 || nr != 3) begin
         failures++;
         $display("FAIL b2b_count: grants=%0d responses=%0d required 3 3", ng, nr);
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_out_of_range();
      int ce_seen;
      ce_seen = 0;
      for (int c = 0; c < 6; c++) begin
         cyc();
         req0 = (c == 0); addr0 = 32'h0001_0000; we0 = 1'b0; be0 = 4'hF;
         #1;
         if (ce0) ce_seen++;
         if (c == 3) begin
            checks++;
            if (rvalid0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== 32'h0) begin
               failures++;
               $display("FAIL oor_resp: rvalid=%b err=%b rdata=%h required 1 1 0", rvalid0, err0, rdata0);
            end
         end
      end
      checks++;
      if (ce_seen != 0) begin
         failures++;
         $display("FAIL oor_ce: ce high for %0d cycles required 0", ce_seen);
      end
      $display("test_out_of_range done");
   endtask

   task automatic test_wait_states();
      logic [31:0] rd; logic e; int lat;
      txn3(32'h1C, 1'b1, 4'hF, 32'hCAFEF00D, rd, e, lat);
      checks++;
      if (lat !== 6) begin failures++; $display("FAIL ws_write_lat: got %0d required 6", lat); end
      for (int c = 0; c < 14; c++) begin
         cyc();
         req3 = (c <= 6); addr3 = 32'h1C; we3 = 1'b0; be3 = 4'hF;
         #1;
         if (c == 0 || c == 6) begin
            checks++;
            if (gnt3 !== 1'b1) begin failures++; $display("FAIL ws_gnt_c%0d: got %b required 1", c, gnt3); end
         end else if (c < 6) begin
            checks++;
            if (gnt3 !== 1'b0 || rvalid3 !== 1'b0) begin
               failures++;
               $display("FAIL ws_hold_c%0d: gnt=%b rvalid=%b required 0 0", c, gnt3, rvalid3);
            end
         end
         if (c == 6 || c == 12) begin
            checks++;
            if (rvalid3 !== 1'b1 || rdata3 !== 32'hCAFEF00D || err3 !== 1'b0) begin
               failures++;
               $display("FAIL ws_resp_c%0d: rvalid=%b rdata=%h err=%b required 1 cafef00d 0", c, rvalid3, rdata3, err3);
            end
         end
      end
      req3 = 1'b0;
      $display("test_wait_states done");
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic e; int lat; int stray;
      cyc(); req3 = 1'b1; addr3 = 32'h1C; we3 = 1'b0; be3 = 4'hF;
      cyc(); req3 = 1'b0;
      cyc(); cyc(); cyc();
      // Now in the second WAIT cycle; reset must act without a clock edge.
      rst = 1'b1; req3 = 1'b1; #1;
      checks++;
      if ({gnt3, rvalid3, err3, ce3, swe3, sbe3} !== 9'b0 || rdata3 !== 32'h0) begin
         failures++;
         $display("FAIL rstmid_outputs: gnt=%b rvalid=%b err=%b ce=%b rdata=%h required all 0",
                  gnt3, rvalid3, err3, ce3, rdata3);
      end
      cyc(); rst = 1'b0; req3 = 1'b0;
      stray = 0;
      for (int c = 0; c < 12; c++) begin
         cyc(); #1;
         if (rvalid3) stray++;
      end
      checks++;
      if (stray != 0) begin failures++; $display("FAIL rstmid_stray: rvalid pulses=%0d required 0", stray); end
      txn3(32'h1C, 1'b0, 4'hF, 32'h0, rd, e, lat);
      checks++;
      if (lat !== 6 || rd !== 32'hCAFEF00D || e !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_next: lat=%0d rdata=%h err=%b required 6 cafef00d 0", lat, rd, e);
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_read();
      test_byte_write();
      test_back_to_back();
      test_out_of_range();
      test_wait_states();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller that terminates the core's data interface (req/gnt/rvalid handshake from the EX-stage LSU) and drives one synchronous single-port SRAM with byte-write enables. Sits directly downstream of the core top on the data side. One outstanding transaction at a time, with a configurable response wait-state count and an out-of-range error response.

## Interface
Parameters:
- ADDR_WIDTH, 14, SRAM word-address bits (capacity 2^ADDR_WIDTH 32-bit words).
- WAIT_CYCLES, 0, extra cycles inserted before each response, legal range 0..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- data_req_i  in  1  request from core; address, we, be and wdata stable while high.
- data_gnt_o  out  1  grant; combinational.
- data_rvalid_o  out  1  response valid, one-cycle pulse; registered.
- data_addr_i  in  32  byte address.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables, bit n covers wdata[8n+7:8n].
- data_wdata_i  in  32  write data.
- data_rdata_o  out  32  read data, valid with rvalid; registered.
- data_err_o  out  1  error flag, valid with rvalid; registered.
- sram_ce_o  out  1  SRAM chip enable.
- sram_we_o  out  1  SRAM write enable.
- sram_be_o  out  4  SRAM byte-write enables.
- sram_addr_o  out  ADDR_WIDTH  SRAM word address.
- sram_wdata_o  out  32  SRAM write data.
- sram_rdata_i  in  32  SRAM read data; valid the cycle after a read ce.

## Operation
- States:
  - IDLE: wait for a request.
  - ACCESS: drive SRAM for one cycle.
  - LATCH: capture sram_rdata_i into rdata_q.
  - WAIT: count WAIT_CYCLES; skipped when WAIT_CYCLES = 0.
  - RESP: drive the registered response.
- Grant rule: data_gnt_o = data_req_i & (state == IDLE | state == RESP). A grant in RESP gives back-to-back service.
- On grant, latch addr, we, be and wdata, then go to ACCESS. Without a grant, RESP returns to IDLE.
- Range check: err = |data_addr_i[31:ADDR_WIDTH+2]. Word index = addr[ADDR_WIDTH+1:2]. addr[1:0] is ignored.
- ACCESS: sram_ce_o = !err_q; sram_we_o, sram_be_o, sram_addr_o and sram_wdata_o come from the latched values. All SRAM outputs are 0 in every other state.
- LATCH: if read and !err, rdata_q <= sram_rdata_i; otherwise rdata_q <= 0.
- WAIT: the down-counter loads WAIT_CYCLES-1 on entry and exits to RESP at 0. Counter width is max(1, $clog2(WAIT_CYCLES+1)).
- Response outputs are set on the LATCH/WAIT -> RESP edge: rvalid=1, rdata=rdata_q, err=err_q. They clear to 0 on the following edge, also when a new grant occurs in RESP.
- Writes and errors also produce exactly one rvalid, with rdata = 0.
- A write with be = 4'b0000 still issues ce with be 0, so no bytes change.
- Reset (any state, including mid-transaction): state IDLE, counter 0, all latched registers 0, all outputs 0. No rvalid is ever emitted for an aborted transaction.

## Timing
- Request granted in cycle 0:
  - ACCESS in cycle 1.
  - LATCH in cycle 2.
  - WAIT in cycles 3..2+WAIT_CYCLES.
  - data_rvalid_o high in cycle 3+WAIT_CYCLES.
- Sustained throughput: one transaction per 3+WAIT_CYCLES cycles, since the next grant coincides with rvalid.
- data_gnt_o is 0 in ACCESS, LATCH and WAIT. A held request is granted in the first IDLE/RESP cycle.
- Request attributes are sampled only in the grant cycle.
- sram_ce_o is high for exactly one cycle per in-range transaction and never high for errors.

## Structure
- Add dmem_state_e (IDLE, ACCESS, LATCH, WAIT, RESP) to milano_pkg.
- Single module, no sub-module. The wait counter is inline.

## Test plan
- Read, WAIT_CYCLES=0: SRAM word 5 preloaded with 0xDEADBEEF, read addr 0x14 -> gnt in cycle 0, sram_ce/addr=5 in cycle 1, rvalid with rdata 0xDEADBEEF and err 0 in cycle 3.
- Byte write: word 5 = 0xDEADBEEF, write addr 0x14, be=4'b0010, wdata=0x0000AA00 -> rvalid with rdata 0; a following read returns 0xDEADAAEF.
- Wait states, WAIT_CYCLES=3: read -> rvalid in cycle 6; gnt stays 0 in cycles 1-5 while req is held.
- Back-to-back, WAIT_CYCLES=0: three reads with req held continuously -> grants in cycles 0, 3 and 6; rvalid in cycles 3, 6 and 9, each with the correct data.
- Out of range, ADDR_WIDTH=14: read at 0x0001_0000 -> sram_ce never asserted; rvalid in cycle 3 with err=1 and rdata=0.
- Reset mid-operation: rst_i pulsed in WAIT -> all outputs 0 immediately, no rvalid afterwards; the next request is served normally.
